// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - parallel-to-serial feeder driving the recognizer X input
module serial_bit_feeder #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              x_out,
    output logic              x_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              x_out_q, x_out_d;
    logic              x_valid_q, x_valid_d;
    logic              busy_q, busy_d;
    // Keeps s_ready low while reset is held and for the reset edge itself.
    logic              rst_done_q, rst_done_d;

    logic              div_wrap;
    logic              last_cycle;
    logic              transfer;

    // Bit that goes out first from a word, honouring the shift direction.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            first_bit = w[DATA_W-1];
        end else begin
            first_bit = w[0];
        end
    endfunction

    // Word with its outgoing bit removed, next bit moved into the output slot.
    function automatic logic [DATA_W-1:0] rest_bits(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            rest_bits = {w[DATA_W-2:0], 1'b0};
        end else begin
            rest_bits = {1'b0, w[DATA_W-1:1]};
        end
    endfunction

    assign div_wrap   = (div_cnt_q == DIV_LAST);
    assign last_cycle = (state_q == ST_SHIFT) && (bit_cnt_q == BIT_LAST) && div_wrap;
    assign transfer   = s_valid && s_ready;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            x_out_q    <= 1'b0;
            x_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            x_out_q    <= x_out_d;
            x_valid_q  <= x_valid_d;
            busy_q     <= busy_d;
            rst_done_q <= rst_done_d;
        end
    end

    // Next state: leave SHIFT after the last hold cycle unless a word chains in.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_cycle && !transfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded purely from registers so s_ready never loops back to s_valid.
    always_comb begin
        s_ready    = rst_done_q && ((state_q == ST_IDLE) || last_cycle);
        frame_done = last_cycle;
    end

    // Shift register, counters and registered serial outputs.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        x_out_d    = x_out_q;
        x_valid_d  = x_valid_q;
        busy_d     = busy_q;
        rst_done_d = 1'b1;
        if (transfer) begin
            // Covers both a fresh start and a chained word on the final cycle.
            shift_d   = rest_bits(s_data);
            bit_cnt_d = '0;
            div_cnt_d = '0;
            x_out_d   = first_bit(s_data);
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (last_cycle) begin
                shift_d   = '0;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                x_out_d   = 1'b0;
                x_valid_d = 1'b0;
                busy_d    = 1'b0;
            end else if (div_wrap) begin
                div_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                x_out_d   = first_bit(shift_q);
                shift_d   = rest_bits(shift_q);
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - self-checking bench for serial_bit_feeder
module tb_serial_bit_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] s_data, sd_s, sd_l;
    logic       s_valid, sv_s, sv_l;
    logic       s_ready, x_out, x_valid, busy, frame_done;
    logic       rdy_s, xo_s, xv_s, bsy_s, fd_s;
    logic       rdy_l, xo_l, xv_l, bsy_l, fd_l;

    serial_bit_feeder #(.DATA_W(4), .CLKS_PER_BIT(1), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .x_out(x_out), .x_valid(x_valid), .busy(busy),
        .frame_done(frame_done)
    );

    serial_bit_feeder #(.DATA_W(4), .CLKS_PER_BIT(3), .MSB_FIRST(1)) dut_s (
        .clk(clk), .reset(reset), .s_data(sd_s), .s_valid(sv_s),
        .s_ready(rdy_s), .x_out(xo_s), .x_valid(xv_s), .busy(bsy_s),
        .frame_done(fd_s)
    );

    serial_bit_feeder #(.DATA_W(4), .CLKS_PER_BIT(1), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .s_data(sd_l), .s_valid(sv_l),
        .s_ready(rdy_l), .x_out(xo_l), .x_valid(xv_l), .busy(bsy_l),
        .frame_done(fd_l)
    );

    typedef struct {
        logic b;
        logic last;
    } sb_t;

    typedef struct {
        logic [3:0] data;
        logic [3:0] exp_seq;
        int         gap;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_on = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        sb_t e;
        @(posedge clk);
        #1;
        if (mon_on) begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_x_valid", x_valid, 1'b1);
                check("sb_x_out", x_out, e.b);
                check("sb_busy", busy, 1'b1);
                check("sb_frame_done", frame_done, e.last);
                check("sb_s_ready", s_ready, e.last);
            end else begin
                check("idle_x_valid", x_valid, 1'b0);
                check("idle_x_out", x_out, 1'b0);
                check("idle_busy", busy, 1'b0);
                check("idle_frame_done", frame_done, 1'b0);
                check("idle_s_ready", s_ready, 1'b1);
            end
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [3:0] exp_seq, input int gap);
        sb_t e;
        int  n;
        n = 0;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            s_data = 4'($urandom);
            cycle();
            n++;
        end
        check("ready_wait_in_bound", (n < 50) ? 1'b1 : 1'b0, 1'b1);
        s_data = d;
        for (int i = 3; i >= 0; i--) begin
            e.b    = exp_seq[i];
            e.last = (i == 0);
            sbq.push_back(e);
        end
        cycle();
        s_valid = 1'b0;
        s_data  = 4'($urandom);
        repeat (gap) cycle();
    endtask

    initial begin
        vecs[0] = '{data: 4'b1010, exp_seq: 4'b1010, gap: 0};
        vecs[1] = '{data: 4'b0101, exp_seq: 4'b0101, gap: 3};
        vecs[2] = '{data: 4'b1100, exp_seq: 4'b1100, gap: 0};
        vecs[3] = '{data: 4'b0011, exp_seq: 4'b0011, gap: 0};
        vecs[4] = '{data: 4'b1111, exp_seq: 4'b1111, gap: 1};
        vecs[5] = '{data: 4'b0000, exp_seq: 4'b0000, gap: 0};
        vecs[6] = '{data: 4'b1001, exp_seq: 4'b1001, gap: 2};
        vecs[7] = '{data: 4'b0110, exp_seq: 4'b0110, gap: 0};

        reset   = 1'b1;
        s_valid = 1'b0;
        sv_s    = 1'b0;
        sv_l    = 1'b0;
        s_data  = 4'b0;
        sd_s    = 4'b0;
        sd_l    = 4'b0;
        cycle();
        cycle();
        check("rst_x_out", x_out, 1'b0);
        check("rst_x_valid", x_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_s_ready_stretch", rdy_s, 1'b0);

        reset = 1'b0;
        cycle();
        check("post_rst_s_ready", s_ready, 1'b1);
        check("post_rst_s_ready_stretch", rdy_s, 1'b1);
        check("post_rst_s_ready_lsb", rdy_l, 1'b1);

        mon_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].exp_seq, vecs[i].gap);
        end
        repeat (6) cycle();

        sv_s = 1'b1;
        sd_s = 4'b1100;
        sv_l = 1'b1;
        sd_l = 4'b1000;
        cycle();
        sv_s = 1'b0;
        sv_l = 1'b0;
        sd_s = 4'b0011;
        sd_l = 4'b0111;
        for (int k = 1; k <= 13; k++) begin
            check("stretch_x_out", xo_s, (k <= 6) ? 1'b1 : 1'b0);
            check("stretch_x_valid", xv_s, (k <= 12) ? 1'b1 : 1'b0);
            check("stretch_busy", bsy_s, (k <= 12) ? 1'b1 : 1'b0);
            check("stretch_frame_done", fd_s, (k == 12) ? 1'b1 : 1'b0);
            check("stretch_s_ready", rdy_s, (k >= 12) ? 1'b1 : 1'b0);
            check("lsb_x_out", xo_l, (k == 4) ? 1'b1 : 1'b0);
            check("lsb_x_valid", xv_l, (k <= 4) ? 1'b1 : 1'b0);
            check("lsb_frame_done", fd_l, (k == 4) ? 1'b1 : 1'b0);
            check("lsb_s_ready", rdy_l, (k >= 4) ? 1'b1 : 1'b0);
            cycle();
        end

        mon_on  = 1'b0;
        s_valid = 1'b1;
        s_data  = 4'b1111;
        cycle();
        s_valid = 1'b0;
        s_data  = 4'b0000;
        cycle();
        cycle();
        check("mid_bit2_x_out", x_out, 1'b1);
        check("mid_bit2_x_valid", x_valid, 1'b1);
        reset = 1'b1;
        cycle();
        check("abort_x_out", x_out, 1'b0);
        check("abort_x_valid", x_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_s_ready", s_ready, 1'b0);
        check("abort_frame_done", frame_done, 1'b0);
        sbq.delete();
        reset = 1'b0;
        cycle();
        check("abort_recover_s_ready", s_ready, 1'b1);
        check("abort_recover_x_valid", x_valid, 1'b0);
        mon_on = 1'b1;
        send(4'b0110, 4'b0110, 0);
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
